// File: rtl/spi_pkg.sv
// Shared types and frame-length constants for the SPI transmit master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FPORCH,
        ACTIVE,
        BPORCH
    } spi_tx_state_t;

    localparam int unsigned SPI_LEN8_BITS  = 8;
    localparam int unsigned SPI_LEN16_BITS = 16;

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period divider: one-cycle tick every SCLK_DIV clocks while enabled.
module spi_half_tick #(
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = $clog2(SCLK_DIV);

    if (SCLK_DIV < 2) begin : g_bad_div
        $error("spi_half_tick: SCLK_DIV must be >= 2");
    end

    logic [CW-1:0] cnt;

    always_comb begin
        tick = en && (cnt == CW'(SCLK_DIV - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_tx_mstr.sv
// SPI master transmitter: 8/16-bit MSB-first frames with selectable sample edge,
// MISO captured through a 2-flop synchronizer into rd_data at frame end.
module spi_tx_mstr
    import spi_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        len8,
    input  logic        edg,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        busy,
    output logic        done,
    output logic [15:0] rd_data
);

    spi_tx_state_t state;
    logic          tick;
    logic          edg_q;
    logic          len8_q;
    logic [14:0]   tx_rem;
    logic [15:0]   rx_sr;
    logic [4:0]    bit_cnt;
    logic [4:0]    frame_bits;
    logic          miso_meta;
    logic          miso_s;

    spi_half_tick #(
        .SCLK_DIV(SCLK_DIV)
    ) u_half_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state != IDLE),
        .tick (tick)
    );

    always_comb begin
        frame_bits = len8_q ? 5'(SPI_LEN8_BITS) : 5'(SPI_LEN16_BITS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_meta <= 1'b0;
            miso_s    <= 1'b0;
        end else begin
            miso_meta <= MISO;
            miso_s    <= miso_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            SS_n    <= 1'b1;
            SCLK    <= 1'b0;
            MOSI    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
            edg_q   <= 1'b1;
            len8_q  <= 1'b0;
            tx_rem  <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    edg_q <= edg;
                    SCLK  <= !edg_q;
                    MOSI  <= 1'b0;
                    SS_n  <= 1'b1;
                    if (wrt) begin
                        tx_rem  <= len8 ? {cmd[6:0], 8'h00} : cmd[14:0];
                        MOSI    <= len8 ? cmd[7] : cmd[15];
                        len8_q  <= len8;
                        SCLK    <= !edg;
                        SS_n    <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        rx_sr   <= '0;
                        state   <= FPORCH;
                    end
                end
                // Porch tick only hands over to ACTIVE; the first sample edge lands one
                // half-period later so SS_n spans 2N+2 half-periods in total.
                FPORCH: begin
                    if (tick) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (tick) begin
                        if (SCLK != edg_q) begin
                            SCLK    <= edg_q;
                            rx_sr   <= {rx_sr[14:0], miso_s};
                            bit_cnt <= bit_cnt + 5'd1;
                        end else begin
                            SCLK <= !edg_q;
                            if (bit_cnt == frame_bits) begin
                                state <= BPORCH;
                            end else begin
                                MOSI   <= tx_rem[14];
                                tx_rem <= {tx_rem[13:0], 1'b0};
                            end
                        end
                    end
                end
                BPORCH: begin
                    if (tick) begin
                        SS_n    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        MOSI    <= 1'b0;
                        rd_data <= len8_q ? {8'h00, rx_sr[7:0]} : rx_sr;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_mstr.sv
// Scoreboard bench for spi_tx_mstr: frames push expectations, a negedge monitor checks each done.
module tb_spi_tx_mstr;

    logic        clk;
    logic        rst_n;
    logic        wrt;
    logic [15:0] cmd;
    logic        len8;
    logic        edg;
    logic        miso_loop;
    logic        miso_val;
    wire         MISO;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        busy;
    logic        done;
    logic [15:0] rd_data;

    assign MISO = miso_loop ? MOSI : miso_val;

    spi_tx_mstr #(
        .SCLK_DIV(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrt    (wrt),
        .cmd    (cmd),
        .len8   (len8),
        .edg    (edg),
        .MISO   (MISO),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .busy   (busy),
        .done   (done),
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd;
        logic [15:0] bits;
        int unsigned n;
        int unsigned ss_low;
        logic        edg;
    } exp_t;

    exp_t exp_q[$];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned done_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: accumulate frame observations, compare against the scoreboard on done.
    logic [15:0] rise_bits, fall_bits;
    int unsigned rise_n, fall_n, low_cnt;
    logic        prev_sclk, prev_ss;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            rise_bits = '0;
            fall_bits = '0;
            rise_n    = 0;
            fall_n    = 0;
            low_cnt   = 0;
            prev_sclk = SCLK;
            prev_ss   = 1'b1;
        end else begin
            if (!SS_n && !prev_ss && (SCLK != prev_sclk)) begin
                if (SCLK) begin
                    rise_bits = {rise_bits[14:0], MOSI};
                    rise_n++;
                end else begin
                    fall_bits = {fall_bits[14:0], MOSI};
                    fall_n++;
                end
            end
            if (!SS_n) low_cnt++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1 expected no done at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", {16'h0, rd_data}, {16'h0, e.rd});
                    check("ss_low_clks", low_cnt, e.ss_low);
                    check("mosi_bits", {16'h0, (e.edg ? rise_bits : fall_bits)}, {16'h0, e.bits});
                    check("sample_edges", e.edg ? rise_n : fall_n, e.n);
                    check("sclk_idle_at_done", {31'h0, SCLK}, {31'h0, !e.edg});
                end
                rise_bits = '0;
                fall_bits = '0;
                rise_n    = 0;
                fall_n    = 0;
                low_cnt   = 0;
            end
            prev_sclk = SCLK;
            prev_ss   = SS_n;
        end
    end

    task automatic start_frame(input logic [15:0] c, input logic l8, input logic ed,
                               input logic loop, input logic mval, input bit push,
                               input logic [15:0] exp_rd, input logic [15:0] exp_bits,
                               input int unsigned exp_n, input int unsigned exp_low);
        exp_t x;
        cmd       = c;
        len8      = l8;
        edg       = ed;
        miso_loop = loop;
        miso_val  = mval;
        repeat (3) @(negedge clk);
        check("sclk_idle_level", {31'h0, SCLK}, {31'h0, !ed});
        if (push) begin
            x.rd = exp_rd; x.bits = exp_bits; x.n = exp_n; x.ss_low = exp_low; x.edg = ed;
            exp_q.push_back(x);
        end
        wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
    endtask

    task automatic wait_done();
        int unsigned k;
        k = 0;
        while (!done && k < 600) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL done_timeout: got no done expected done within 600 clks at %0t", $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ss_n"},    {31'h0, SS_n}, 32'h1);
        check({tag, "_sclk"},    {31'h0, SCLK}, 32'h0);
        check({tag, "_mosi"},    {31'h0, MOSI}, 32'h0);
        check({tag, "_busy"},    {31'h0, busy}, 32'h0);
        check({tag, "_done"},    {31'h0, done}, 32'h0);
        check({tag, "_rd_data"}, {16'h0, rd_data}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        wrt       = 1'b0;
        cmd       = '0;
        len8      = 1'b0;
        edg       = 1'b1;
        miso_loop = 1'b1;
        miso_val  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_release");

        // 16-bit, sample on rise, loopback
        start_frame(16'hA5C3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'hA5C3, 16'hA5C3, 16, 136);
        wait_done();
        @(negedge clk);

        // 8-bit, sample on fall, MISO tied high
        start_frame(16'h12F0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00FF, 16'h00F0, 8, 72);
        wait_done();
        @(negedge clk);

        // 16-bit with an ignored wrt and input changes mid-frame
        start_frame(16'h3C96, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h3C96, 16'h3C96, 16, 136);
        repeat (50) @(negedge clk);
        check("rd_data_hold_mid_frame", {16'h0, rd_data}, 32'h0000_00FF);
        check("busy_mid_frame", {31'h0, busy}, 32'h1);
        cmd  = 16'hFFFF;
        len8 = 1'b1;
        edg  = 1'b0;
        wrt  = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
        wait_done();
        @(negedge clk);

        // back-to-back: second wrt issued in the done cycle of the first frame
        start_frame(16'h00C5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00C5, 16'h00C5, 8, 72);
        cmd  = 16'h0001;
        len8 = 1'b0;
        wait_done();
        check("ss_n_high_in_done_cycle", {31'h0, SS_n}, 32'h1);
        exp_q.push_back('{rd: 16'h0001, bits: 16'h0001, n: 16, ss_low: 136, edg: 1'b1});
        wrt = 1'b1;
        @(negedge clk);
        wrt = 1'b0;
        check("b2b_ss_n_low_next_cycle", {31'h0, SS_n}, 32'h0);
        check("b2b_busy", {31'h0, busy}, 32'h1);
        wait_done();
        @(negedge clk);

        // reset asserted at the 40th clock of a frame
        start_frame(16'h5A5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 0, 0);
        repeat (39) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_frame_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        start_frame(16'h0F69, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0F69, 16'h0F69, 16, 136);
        wait_done();
        repeat (5) @(negedge clk);

        check("pending_expectations", exp_q.size(), 32'h0);
        check("done_pulse_count", done_cnt, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
